// File: rtl/baccarat_round_controller_pkg.sv
// Shared types and helpers for the Baccarat round controller: FSM states,
// bet sides, scoring thresholds and the rank-to-value mapping.
package baccarat_pkg;

    typedef enum logic [4:0] {
        S_IDLE,
        S_REQ_P1, S_LD_P1,
        S_REQ_D1, S_LD_D1,
        S_REQ_P2, S_LD_P2,
        S_REQ_D2, S_LD_D2,
        S_DECIDE,
        S_REQ_P3, S_LD_P3,
        S_DECIDE3,
        S_REQ_D3, S_LD_D3,
        S_SETTLE,
        S_FAULT
    } state_t;

    typedef enum logic [1:0] {
        SIDE_PLAYER  = 2'd0,
        SIDE_DEALER  = 2'd1,
        SIDE_TIE     = 2'd2,
        SIDE_ILLEGAL = 2'd3
    } side_t;

    localparam logic [3:0] NATURAL_MIN      = 4'd8;
    localparam logic [3:0] PLAYER_STAND_MIN = 4'd6;
    localparam logic [3:0] DEALER_STAND     = 4'd7;

    // Tens and face cards count as zero; everything else at face value.
    function automatic logic [3:0] card_value(input logic [3:0] rank);
        return (rank >= 4'd10) ? 4'd0 : rank;
    endfunction

endpackage

// File: rtl/baccarat_round_controller_if.sv
// Request/valid card fetch between the round controller (master) and the
// deck source (slave). card_req is a level; a card transfers on any cycle
// where card_req and card_valid are both high.
interface baccarat_card_if;
    logic       card_req;
    logic       card_valid;
    logic [3:0] card_in;

    modport master (output card_req, input card_valid, input card_in);
    modport slave  (input card_req, output card_valid, output card_in);
endinterface

// File: rtl/baccarat_round_controller_draw_rules.sv
// Baccarat third-card tableau. player_drew selects between the two-card
// decision (player_drew=0) and the dealer response to a player third card.
module baccarat_draw_rules
    import baccarat_pkg::*;
(
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    input  logic       player_drew,
    output logic       player_draw,
    output logic       dealer_draw
);

    logic       natural;
    logic       tableau;
    logic [3:0] v;

    // Decide both draws from the current totals and the player's third card.
    always_comb begin
        v           = card_value(pcard3);
        natural     = (pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN);
        player_draw = !natural && (pscore < PLAYER_STAND_MIN);
        tableau     = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: tableau = 1'b1;
            4'd3:             tableau = (v != 4'd8);
            4'd4:             tableau = (v >= 4'd2) && (v <= 4'd7);
            4'd5:             tableau = (v >= 4'd4) && (v <= 4'd7);
            4'd6:             tableau = (v >= 4'd6) && (v <= 4'd7);
            default:          tableau = 1'b0;
        endcase
        // Without a player third card the dealer stands on 6 and 7.
        if (player_drew) begin
            dealer_draw = tableau;
        end else begin
            dealer_draw = !natural && (pscore >= PLAYER_STAND_MIN)
                          && (dscore <= DEALER_STAND - 4'd2);
        end
    end

endmodule

// File: rtl/baccarat_round_controller.sv
// Round scheduler above the card datapath: takes a bet, fetches four to six
// cards over a request/valid handshake, strobes the matching datapath card
// register, applies the draw rules, settles the bankroll and guards against
// a stalled deck with a watchdog.
module baccarat_round_controller
    import baccarat_pkg::*;
#(
    parameter int BANK_W     = 10,
    parameter int INIT_BANK  = 100,
    parameter int TIMEOUT    = 255,
    parameter int TIE_PAYOUT = 8
) (
    input  logic              slow_clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        bet_side,
    input  logic [BANK_W-1:0] bet_amount,
    baccarat_card_if.master   deck,
    output logic [3:0]        card_out,
    input  logic [3:0]        pscore,
    input  logic [3:0]        dscore,
    input  logic [3:0]        pcard3,
    output logic              load_pcard1,
    output logic              load_pcard2,
    output logic              load_pcard3,
    output logic              load_dcard1,
    output logic              load_dcard2,
    output logic              load_dcard3,
    output logic              player_win_light,
    output logic              dealer_win_light,
    output logic [BANK_W-1:0] bankroll,
    output logic              busy,
    output logic              round_done,
    output logic              bet_err,
    output logic              fault
);

    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam int SUM_W = BANK_W + 4;
    localparam logic [SUM_W-1:0] BANK_MAX = {{4{1'b0}}, {BANK_W{1'b1}}};

    state_t            state_q;
    side_t             side_q;
    logic [BANK_W-1:0] bank_q, bet_q;
    logic [WD_W-1:0]   wd_q;
    logic [3:0]        card_q;
    logic              card_req_q;
    logic [5:0]        load_q;  // {d3, d2, d1, p3, p2, p1}
    logic              pwin_q, dwin_q, busy_q, done_q, err_q, fault_q;

    state_t            ld_state_d, after_ld_d;
    logic [5:0]        ld_strobe_d;
    logic              after_is_req_d;
    logic              start_ok_d;
    logic [SUM_W-1:0]  bet_ext_d, credit_d;
    logic [BANK_W-1:0] settle_d;
    logic              player_draw, dealer_draw;

    function automatic logic [BANK_W-1:0] sat_bank(input logic [SUM_W-1:0] x);
        return (x > BANK_MAX) ? '1 : x[BANK_W-1:0];
    endfunction

    baccarat_draw_rules u_rules (
        .pscore      (pscore),
        .dscore      (dscore),
        .pcard3      (pcard3),
        .player_drew (state_q == S_DECIDE3),
        .player_draw (player_draw),
        .dealer_draw (dealer_draw)
    );

    // Map each request state to its load state/strobe, and each load state to its successor.
    always_comb begin
        ld_state_d  = S_IDLE;
        ld_strobe_d = '0;
        after_ld_d  = S_IDLE;
        case (state_q)
            S_REQ_P1: begin ld_state_d = S_LD_P1; ld_strobe_d = 6'b000001; end
            S_REQ_D1: begin ld_state_d = S_LD_D1; ld_strobe_d = 6'b001000; end
            S_REQ_P2: begin ld_state_d = S_LD_P2; ld_strobe_d = 6'b000010; end
            S_REQ_D2: begin ld_state_d = S_LD_D2; ld_strobe_d = 6'b010000; end
            S_REQ_P3: begin ld_state_d = S_LD_P3; ld_strobe_d = 6'b000100; end
            S_REQ_D3: begin ld_state_d = S_LD_D3; ld_strobe_d = 6'b100000; end
            S_LD_P1:  after_ld_d = S_REQ_D1;
            S_LD_D1:  after_ld_d = S_REQ_P2;
            S_LD_P2:  after_ld_d = S_REQ_D2;
            S_LD_D2:  after_ld_d = S_DECIDE;
            S_LD_P3:  after_ld_d = S_DECIDE3;
            S_LD_D3:  after_ld_d = S_SETTLE;
            default:  ;
        endcase
        after_is_req_d = (after_ld_d == S_REQ_D1) || (after_ld_d == S_REQ_P2)
                         || (after_ld_d == S_REQ_D2);
    end

    // Bet acceptance and settlement credit at widened precision.
    always_comb begin
        start_ok_d = (bet_amount != '0) && (bet_amount <= bank_q)
                     && (bet_side != SIDE_ILLEGAL);
        bet_ext_d  = {4'b0, bet_q};
        credit_d   = '0;
        case (side_q)
            SIDE_PLAYER: begin
                if (pscore > dscore)       credit_d = bet_ext_d << 1;
                else if (pscore == dscore) credit_d = bet_ext_d;
            end
            SIDE_DEALER: begin
                if (dscore > pscore)       credit_d = bet_ext_d << 1;
                else if (pscore == dscore) credit_d = bet_ext_d;
            end
            SIDE_TIE: begin
                if (pscore == dscore)      credit_d = bet_ext_d * SUM_W'(TIE_PAYOUT + 1);
            end
            default: credit_d = '0;
        endcase
        settle_d = sat_bank({4'b0, bank_q} + credit_d);
    end

    // Round FSM with all outputs registered.
    always_ff @(posedge slow_clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            side_q     <= SIDE_PLAYER;
            bank_q     <= BANK_W'(INIT_BANK);
            bet_q      <= '0;
            wd_q       <= '0;
            card_q     <= '0;
            card_req_q <= 1'b0;
            load_q     <= '0;
            pwin_q     <= 1'b0;
            dwin_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            load_q <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (start_ok_d) begin
                            bank_q     <= bank_q - bet_amount;
                            bet_q      <= bet_amount;
                            side_q     <= side_t'(bet_side);
                            pwin_q     <= 1'b0;
                            dwin_q     <= 1'b0;
                            busy_q     <= 1'b1;
                            card_req_q <= 1'b1;
                            wd_q       <= '0;
                            state_q    <= S_REQ_P1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_REQ_P1, S_REQ_D1, S_REQ_P2, S_REQ_D2, S_REQ_P3, S_REQ_D3: begin
                    if (deck.card_valid) begin
                        card_q     <= deck.card_in;
                        card_req_q <= 1'b0;
                        wd_q       <= '0;
                        load_q     <= ld_strobe_d;
                        state_q    <= ld_state_d;
                    end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                        // Deck stalled: give the stake back and park until start.
                        bank_q     <= bank_q + bet_q;
                        card_req_q <= 1'b0;
                        busy_q     <= 1'b0;
                        fault_q    <= 1'b1;
                        wd_q       <= '0;
                        state_q    <= S_FAULT;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                S_LD_P1, S_LD_D1, S_LD_P2, S_LD_D2, S_LD_P3, S_LD_D3: begin
                    card_req_q <= after_is_req_d;
                    state_q    <= after_ld_d;
                end
                S_DECIDE: begin
                    if (player_draw) begin
                        card_req_q <= 1'b1;
                        state_q    <= S_REQ_P3;
                    end else if (dealer_draw) begin
                        card_req_q <= 1'b1;
                        state_q    <= S_REQ_D3;
                    end else begin
                        state_q <= S_SETTLE;
                    end
                end
                S_DECIDE3: begin
                    if (dealer_draw) begin
                        card_req_q <= 1'b1;
                        state_q    <= S_REQ_D3;
                    end else begin
                        state_q <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    bank_q  <= settle_d;
                    pwin_q  <= (pscore >= dscore);
                    dwin_q  <= (dscore >= pscore);
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_FAULT: begin
                    if (start) begin
                        fault_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign deck.card_req     = card_req_q;
    assign card_out          = card_q;
    assign load_pcard1       = load_q[0];
    assign load_pcard2       = load_q[1];
    assign load_pcard3       = load_q[2];
    assign load_dcard1       = load_q[3];
    assign load_dcard2       = load_q[4];
    assign load_dcard3       = load_q[5];
    assign player_win_light  = pwin_q;
    assign dealer_win_light  = dwin_q;
    assign bankroll          = bank_q;
    assign busy              = busy_q;
    assign round_done        = done_q;
    assign bet_err           = err_q;
    assign fault             = fault_q;

endmodule

// File: tb/tb_baccarat_round_controller.sv
// Bench for baccarat_round_controller: a deck source and datapath model
// feed the DUT, a reference round model pushes expected results to a
// scoreboard that is popped on every round_done.
module tb_baccarat_round_controller;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [1:0] bet_side;
    logic [9:0] bet_amount;
    logic [3:0] card_out, pscore, dscore, pcard3;
    logic       lp1, lp2, lp3, ld1, ld2, ld3;
    logic       pwl, dwl;
    logic [9:0] bankroll;
    logic       busy, round_done, bet_err, fault;

    baccarat_card_if deck_if ();

    always #5 clk = ~clk;

    baccarat_round_controller #(
        .BANK_W(10), .INIT_BANK(100), .TIMEOUT(255), .TIE_PAYOUT(8)
    ) dut (
        .slow_clock       (clk),
        .reset            (reset),
        .start            (start),
        .bet_side         (bet_side),
        .bet_amount       (bet_amount),
        .deck             (deck_if),
        .card_out         (card_out),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .load_pcard1      (lp1),
        .load_pcard2      (lp2),
        .load_pcard3      (lp3),
        .load_dcard1      (ld1),
        .load_dcard2      (ld2),
        .load_dcard3      (ld3),
        .player_win_light (pwl),
        .dealer_win_light (dwl),
        .bankroll         (bankroll),
        .busy             (busy),
        .round_done       (round_done),
        .bet_err          (bet_err),
        .fault            (fault)
    );

    typedef struct {
        int pl;
        int dl;
        int bank;
        int n_p3;
        int n_d3;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   deck_c[6];
    int   deck_n = 0;
    int   deck_idx = 0;
    int   n_p3 = 0;
    int   n_d3 = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int cval(input int r);
        return (r >= 10) ? 0 : r;
    endfunction

    // Reference round: plain Baccarat play from a fixed card order P1 D1 P2 D2 [P3] [D3].
    function automatic exp_t ref_round(input int side, input int bet, input int bank, input int c[6]);
        exp_t e;
        int   p, d, i, v, credit, tot;
        bit   ddraw;
        e.n_p3 = 0;
        e.n_d3 = 0;
        p = (cval(c[0]) + cval(c[2])) % 10;
        d = (cval(c[1]) + cval(c[3])) % 10;
        i = 4;
        if (p < 8 && d < 8) begin
            if (p <= 5) begin
                v = cval(c[i]);
                i++;
                p = (p + v) % 10;
                e.n_p3 = 1;
                ddraw = (d <= 2) || (d == 3 && v != 8) || (d == 4 && v >= 2 && v <= 7)
                        || (d == 5 && v >= 4 && v <= 7) || (d == 6 && v >= 6 && v <= 7);
            end else begin
                ddraw = (d <= 5);
            end
            if (ddraw) begin
                d = (d + cval(c[i])) % 10;
                e.n_d3 = 1;
            end
        end
        e.pl = (p >= d) ? 1 : 0;
        e.dl = (d >= p) ? 1 : 0;
        credit = 0;
        if (side == 0) credit = (p > d) ? 2 * bet : ((p == d) ? bet : 0);
        if (side == 1) credit = (d > p) ? 2 * bet : ((p == d) ? bet : 0);
        if (side == 2) credit = (p == d) ? 9 * bet : 0;
        tot = bank - bet + credit;
        if (tot > 1023) tot = 1023;
        e.bank = tot;
        return e;
    endfunction

    // Deck source, datapath score registers and scoreboard consumer.
    initial begin
        exp_t e;
        deck_if.card_valid = 1'b0;
        deck_if.card_in    = 4'd0;
        pscore = 4'd0;
        dscore = 4'd0;
        pcard3 = 4'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                deck_idx = 0;
                pscore = 4'd0;
                dscore = 4'd0;
                pcard3 = 4'd0;
                n_p3 = 0;
                n_d3 = 0;
            end else begin
                if ({lp1, lp2, lp3, ld1, ld2, ld3} != 6'b0) begin
                    chk("one_strobe", $countones({lp1, lp2, lp3, ld1, ld2, ld3}), 1);
                    chk("card_out", card_out, (deck_idx < deck_n) ? deck_c[deck_idx] : -1);
                    deck_idx++;
                    if (lp1 || lp2 || lp3) pscore = 4'((int'(pscore) + cval(int'(card_out))) % 10);
                    if (ld1 || ld2 || ld3) dscore = 4'((int'(dscore) + cval(int'(card_out))) % 10);
                    if (lp3) begin
                        pcard3 = card_out;
                        n_p3++;
                    end
                    if (ld3) n_d3++;
                end
                if (round_done) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_empty", 0, 1);
                    end else begin
                        e = sb_q.pop_front();
                        chk("player_light", pwl, e.pl);
                        chk("dealer_light", dwl, e.dl);
                        chk("bankroll", bankroll, e.bank);
                        chk("pcard3_loads", n_p3, e.n_p3);
                        chk("dcard3_loads", n_d3, e.n_d3);
                    end
                end
            end
            deck_if.card_valid = deck_if.card_req && !reset && (deck_idx < deck_n);
            deck_if.card_in    = (deck_idx < deck_n) ? 4'(deck_c[deck_idx]) : 4'd0;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_start(input int side, input int bet);
        bet_side   = 2'(side);
        bet_amount = 10'(bet);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic run_round(input int side, input int bet, input int c[6], input int n);
        bit done;
        do_reset();
        deck_c = c;
        deck_n = n;
        sb_q.push_back(ref_round(side, bet, 100, c));
        pulse_start(side, bet);
        chk("debit", bankroll, 100 - bet);
        chk("busy_round", busy, 1);
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (round_done) done = 1'b1;
        end
        chk("round_done_seen", done, 1);
        if (!done) sb_q.delete();
        @(negedge clk);
        chk("done_one_pulse", round_done, 0);
        chk("idle_not_busy", busy, 0);
        chk("cards_used", deck_idx, n);
    endtask

    initial begin
        int  cnt;
        bit  ok;
        int  bad_amt[3];
        int  bad_side[3];
        reset = 1'b1;
        start = 1'b0;
        bet_side = 2'd0;
        bet_amount = 10'd0;
        deck_c = '{0, 0, 0, 0, 0, 0};
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_bankroll", bankroll, 100);
        chk("rst_busy", busy, 0);
        chk("rst_card_req", deck_if.card_req, 0);

        // Player natural 9 vs 5.
        run_round(0, 10, '{9, 3, 13, 2, 0, 0}, 4);

        // Reset in IDLE clears the held lights and the winnings.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_rst_plight", pwl, 0);
        chk("idle_rst_bank", bankroll, 100);
        reset = 1'b0;

        // Reset mid-round while waiting for the player's second card.
        do_reset();
        deck_c = '{5, 6, 0, 0, 0, 0};
        deck_n = 2;
        pulse_start(0, 10);
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (deck_idx == 2 && deck_if.card_req) ok = 1'b1;
        end
        chk("reach_req_p2", ok, 1);
        chk("mid_bank_debited", bankroll, 90);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_bank", bankroll, 100);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_card_req", deck_if.card_req, 0);
        chk("mid_rst_strobes", {lp1, lp2, lp3, ld1, ld2, ld3}, 0);
        chk("mid_rst_lights", {pwl, dwl}, 0);
        chk("mid_rst_card_out", card_out, 0);
        chk("mid_rst_flags", {round_done, bet_err, fault}, 0);
        reset = 1'b0;

        // Tie bet: player draws an ace, dealer stands on 6.
        run_round(2, 5, '{2, 3, 3, 3, 1, 0}, 5);
        // Dealer bet: player stands on 6, dealer draws to 9.
        run_round(1, 20, '{6, 2, 13, 3, 4, 0}, 5);
        // Player draws an 8, dealer on 3 stands and wins.
        run_round(0, 50, '{1, 2, 3, 1, 8, 7}, 5);
        // Both draw, tie on zero: player bet is pushed.
        run_round(0, 40, '{3, 4, 2, 13, 5, 6}, 6);

        // Rejected starts: over bankroll, zero wager, illegal side.
        do_reset();
        bad_amt  = '{200, 0, 10};
        bad_side = '{0, 0, 3};
        for (int j = 0; j < 3; j++) begin
            pulse_start(bad_side[j], bad_amt[j]);
            chk("bet_err_pulse", bet_err, 1);
            chk("bet_err_no_req", deck_if.card_req, 0);
            chk("bet_err_bank", bankroll, 100);
            @(negedge clk);
            chk("bet_err_one_cycle", bet_err, 0);
            chk("bet_err_idle", busy, 0);
        end

        // Deck stalls after the first card: watchdog fault and refund.
        do_reset();
        deck_c = '{7, 0, 0, 0, 0, 0};
        deck_n = 1;
        pulse_start(1, 30);
        chk("fault_debit", bankroll, 70);
        cnt = 0;
        for (int k = 0; k < 600 && !fault; k++) begin
            @(negedge clk);
            if (!fault && deck_if.card_req && deck_idx == 1) cnt++;
        end
        chk("fault_set", fault, 1);
        chk("fault_wait_cycles", cnt, 255);
        chk("fault_no_req", deck_if.card_req, 0);
        chk("fault_refund", bankroll, 100);
        chk("fault_not_busy", busy, 0);
        pulse_start(1, 30);
        chk("fault_cleared", fault, 0);
        chk("fault_start_no_bet", bankroll, 100);
        @(negedge clk);
        chk("fault_clear_no_req", deck_if.card_req, 0);
        chk("fault_clear_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got %0d expected %0d", checks, -1);
        $fatal(1, "bench timeout");
    end

endmodule
